// File: rtl/a_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : a_frame_packer
// Brief    : Packs a valid/ready byte stream into 8-lane a_if frames with a
//            minimum inter-frame gap and padding of short frames.
//            Optional macro A_PACK_CHECKSUM_EN: 7 data lanes, a7 = XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
module a_frame_packer #(
   parameter int unsigned GAP_CYCLES = 0,
   parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        valid,
   output logic [7:0]  a,
   output logic [7:0]  a1,
   output logic [7:0]  a2,
   output logic [7:0]  a3,
   output logic [7:0]  a4,
   output logic [7:0]  a5,
   output logic [7:0]  a6,
   output logic [7:0]  a7,
   output logic [15:0] frame_count
);

`ifdef A_PACK_CHECKSUM_EN
   localparam int unsigned FRAME_LEN = 7;
`else
   localparam int unsigned FRAME_LEN = 8;
`endif
   localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);
   localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

   typedef enum logic [0:0] {
      S_FILL = 1'b0,
      S_PEND = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       fill_q, fill_d;
   logic [3:0]       gap_q, gap_d;
   logic [7:0][7:0]  buf_q, buf_d;
   logic [7:0][7:0]  lanes_q, lanes_d;
   logic             valid_q, valid_d;
   logic [15:0]      count_q, count_d;

   logic [7:0][7:0]  frame_w;
   logic [7:0][7:0]  out_w;
   logic             accept_w;
   logic             complete_w;
   logic             emit_w;

   // Assembled frame: stored bytes, the byte on the bus at the fill slot, pad above it.
   always_comb begin
      frame_w = buf_q;
      if (state_q == S_FILL) begin
         for (int k = 0; k < 8; k++) begin
            if (3'(k) == fill_q) begin
               frame_w[k] = in_data;
            end else if (3'(k) > fill_q) begin
               frame_w[k] = PAD_BYTE;
            end
         end
      end
      out_w = frame_w;
`ifdef A_PACK_CHECKSUM_EN
      out_w[7] = frame_w[0] ^ frame_w[1] ^ frame_w[2] ^ frame_w[3]
               ^ frame_w[4] ^ frame_w[5] ^ frame_w[6];
`endif
   end

   assign accept_w   = (state_q == S_FILL) && in_valid;
   assign complete_w = accept_w && ((fill_q == LAST_IDX) || in_last);
   assign emit_w     = (gap_q == 4'd0) && (complete_w || (state_q == S_PEND));

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      buf_d   = buf_q;
      lanes_d = lanes_q;
      count_d = count_q;
      valid_d = emit_w;
      gap_d   = (gap_q != 4'd0) ? gap_q - 4'd1 : gap_q;

      if (accept_w) begin
         buf_d[fill_q] = in_data;
         fill_d        = fill_q + 3'd1;
      end
      if (complete_w) begin
         fill_d = 3'd0;
         buf_d  = frame_w;
         if (gap_q != 4'd0) begin
            state_d = S_PEND;
         end
      end
      if ((state_q == S_PEND) && (gap_q == 4'd0)) begin
         state_d = S_FILL;
      end
      if (emit_w) begin
         lanes_d = out_w;
         count_d = count_q + 16'd1;
         gap_d   = GAP_INIT;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_FILL;
         fill_q  <= 3'd0;
         gap_q   <= 4'd0;
         buf_q   <= '0;
         lanes_q <= '0;
         valid_q <= 1'b0;
         count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         gap_q   <= gap_d;
         buf_q   <= buf_d;
         lanes_q <= lanes_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign in_ready    = (state_q == S_FILL);
   assign valid       = valid_q;
   assign frame_count = count_q;
   assign a           = lanes_q[0];
   assign a1          = lanes_q[1];
   assign a2          = lanes_q[2];
   assign a3          = lanes_q[3];
   assign a4          = lanes_q[4];
   assign a5          = lanes_q[5];
   assign a6          = lanes_q[6];
   assign a7          = lanes_q[7];

endmodule
`default_nettype wire

// File: tb/tb_a_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_a_frame_packer
// Brief    : Two packers (gap 0 / pad EE, gap 3 / pad 5A) checked against a
//            frame-level model; honours A_PACK_CHECKSUM_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_a_frame_packer;

   localparam int         GAP0 = 0;
   localparam int         GAP1 = 3;
   localparam logic [7:0] PAD0 = 8'hEE;
   localparam logic [7:0] PAD1 = 8'h5A;
`ifdef A_PACK_CHECKSUM_EN
   localparam int          NB       = 7;
   localparam logic [63:0] EXP_CONT = 64'h010204081020407F;
   localparam logic [63:0] EXP_TOG  = 64'h0102030405060700;
   localparam logic [63:0] EXP_PAD  = 64'hAABBCCEEEEEEEEDD;
   localparam logic [63:0] EXP_RST  = 64'h1112131415161710;
   localparam logic [63:0] EXP_GAP  = 64'h2E2F995A5A5A5A98;
`else
   localparam int          NB       = 8;
   localparam logic [63:0] EXP_CONT = 64'h0102030405060708;
   localparam logic [63:0] EXP_TOG  = 64'h0102030405060708;
   localparam logic [63:0] EXP_PAD  = 64'hAABBCCEEEEEEEEEE;
   localparam logic [63:0] EXP_RST  = 64'h1112131415161718;
   localparam logic [63:0] EXP_GAP  = 64'h995A5A5A5A5A5A5A;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        iv [2];
   logic [7:0]  id [2];
   logic        il [2];
   logic        rdy[2];
   logic        vld[2];
   logic [7:0]  ao [2][8];
   logic [15:0] cnt[2];

   a_frame_packer #(.GAP_CYCLES(GAP0), .PAD_BYTE(PAD0)) u_p0 (
      .clock(clk), .reset(rst_n), .in_valid(iv[0]), .in_data(id[0]), .in_last(il[0]),
      .in_ready(rdy[0]), .valid(vld[0]),
      .a(ao[0][0]), .a1(ao[0][1]), .a2(ao[0][2]), .a3(ao[0][3]),
      .a4(ao[0][4]), .a5(ao[0][5]), .a6(ao[0][6]), .a7(ao[0][7]),
      .frame_count(cnt[0])
   );

   a_frame_packer #(.GAP_CYCLES(GAP1), .PAD_BYTE(PAD1)) u_p1 (
      .clock(clk), .reset(rst_n), .in_valid(iv[1]), .in_data(id[1]), .in_last(il[1]),
      .in_ready(rdy[1]), .valid(vld[1]),
      .a(ao[1][0]), .a1(ao[1][1]), .a2(ao[1][2]), .a3(ao[1][3]),
      .a4(ao[1][4]), .a5(ao[1][5]), .a6(ao[1][6]), .a7(ao[1][7]),
      .frame_count(cnt[1])
   );

   int n_tot  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [63:0] lanes(input int i);
      return {ao[i][0], ao[i][1], ao[i][2], ao[i][3], ao[i][4], ao[i][5], ao[i][6], ao[i][7]};
   endfunction

   function automatic int gapv(input int i);
      return (i == 0) ? GAP0 : GAP1;
   endfunction

   function automatic logic [7:0] padv(input int i);
      return (i == 0) ? PAD0 : PAD1;
   endfunction

   // Reference model: bytes collect into a partial frame; a finished frame is
   // either sent at once or parked until the idle-gap budget has run out.
   logic [7:0]  pb  [2][8];
   int          pn  [2];
   bit          pend[2];
   logic [63:0] pfr [2];
   int          gl  [2];
   bit          ev  [2];
   logic [63:0] el  [2];
   logic [15:0] ecnt[2];
   bit          erdy[2];
   bit          acc [2];

   task automatic mreset(input int i);
      pn[i] = 0; pend[i] = 0; gl[i] = 0; ev[i] = 0; el[i] = '0;
      ecnt[i] = '0; erdy[i] = 1; acc[i] = 0;
   endtask

   task automatic mstep(input int i);
      logic [63:0] fr;
      logic [7:0]  cs;
      bit          emit;
      emit = 0; acc[i] = 0; fr = '0;
      if (pend[i]) begin
         if (gl[i] == 0) begin
            emit = 1; fr = pfr[i]; pend[i] = 0;
         end
      end else if (iv[i]) begin
         acc[i] = 1;
         pb[i][pn[i]] = id[i];
         pn[i]++;
         if (pn[i] == NB || il[i]) begin
            for (int k = 0; k < 8; k++)
               fr[63-8*k -: 8] = (k < pn[i]) ? pb[i][k] : padv(i);
            pn[i] = 0;
            if (gl[i] == 0) emit = 1;
            else begin pend[i] = 1; pfr[i] = fr; end
         end
      end
      if (emit) begin
`ifdef A_PACK_CHECKSUM_EN
         cs = 8'h00;
         for (int k = 0; k < 7; k++) cs = cs ^ fr[63-8*k -: 8];
         fr[7:0] = cs;
`endif
         ev[i] = 1; el[i] = fr; ecnt[i] = ecnt[i] + 16'd1; gl[i] = gapv(i);
      end else begin
         ev[i] = 0;
         if (gl[i] > 0) gl[i]--;
      end
      erdy[i] = !pend[i];
   endtask

   initial begin
      for (int i = 0; i < 2; i++) mreset(i);
      forever begin
         @(posedge clk or negedge rst_n);
         for (int i = 0; i < 2; i++) begin
            if (!rst_n) mreset(i);
            else mstep(i);
         end
      end
   end

   bit chk_en = 0;
   int cyc = 0;
   int lastv[2] = '{-1, -1};

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
               check($sformatf("valid%0d", i), vld[i], ev[i]);
               check($sformatf("ready%0d", i), rdy[i], erdy[i]);
               check($sformatf("count%0d", i), cnt[i], ecnt[i]);
               check($sformatf("lanes%0d", i), lanes(i), el[i]);
               if (!rst_n) lastv[i] = -1;
               else if (vld[i]) begin
                  if (lastv[i] >= 0)
                     check($sformatf("spacing%0d", i), (cyc - lastv[i] - 1) >= gapv(i), 1);
                  lastv[i] = cyc;
               end
            end
         end
      end
   end

   task automatic send(input int i, input logic [7:0] d, input logic l);
      int t;
      iv[i] = 1; id[i] = d; il[i] = l; t = 0;
      forever begin
         @(posedge clk); #1;
         if (acc[i] || t >= 64) break;
         t++;
      end
      check($sformatf("accept%0d", i), acc[i], 1);
      iv[i] = 0; il[i] = 0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin iv[i] = 0; id[i] = '0; il[i] = 0; end
      tick(2);
      chk_en = 1;
      tick(1);
      check("rst_valid", vld[0], 0);
      check("rst_lanes", lanes(0), 64'h0);
      check("rst_ready", rdy[0], 1);
      rst_n = 1;

      // contiguous full frame (checksum build: one-hot bytes)
      for (int k = 0; k < NB; k++) begin
`ifdef A_PACK_CHECKSUM_EN
         send(0, 8'(1 << k), 0);
`else
         send(0, 8'(k + 1), 0);
`endif
      end
      check("cont_valid", vld[0], 1);
      check("cont_lanes", lanes(0), EXP_CONT);
      check("cont_count", cnt[0], 16'd1);

      // short frame with padding, then a new frame starts in lane a
      send(0, 8'hAA, 0);
      send(0, 8'hBB, 0);
      send(0, 8'hCC, 1);
      check("pad_valid", vld[0], 1);
      check("pad_lanes", lanes(0), EXP_PAD);
      send(0, 8'h05, 1);
      check("pad_next_a", lanes(0) >> 56, 64'h05);
      check("pad_count", cnt[0], 16'd3);

      // in_valid toggling between bytes
      for (int k = 0; k < NB; k++) begin
         send(0, 8'(k + 1), 0);
         if (k == NB - 1) begin
            check("tog_valid", vld[0], 1);
            check("tog_lanes", lanes(0), EXP_TOG);
         end
         tick(1);
      end
      check("tog_count", cnt[0], 16'd4);

      // reset in the middle of a frame
      for (int k = 0; k < 4; k++) send(0, 8'(k + 1), 0);
      rst_n = 0;
      tick(1);
      check("mid_rst_valid", vld[0], 0);
      check("mid_rst_lanes", lanes(0), 64'h0);
      check("mid_rst_count", cnt[0], 16'd0);
      rst_n = 1;
      tick(1);
      for (int k = 0; k < NB; k++) send(0, 8'(8'h11 + k), 0);
      check("post_rst_lanes", lanes(0), EXP_RST);
      check("post_rst_count", cnt[0], 16'd1);

      // gap of 3: continuous stream, then a short frame forced into waiting
      for (int k = 0; k < 16; k++) send(1, 8'(8'h20 + k), 0);
      send(1, 8'h99, 1);
      check("gap_pend_ready", rdy[1], 0);
      check("gap_pend_valid", vld[1], 0);
      tick(6);
      check("gap_count", cnt[1], 16'd3);
      check("gap_lanes", lanes(1), EXP_GAP);

      // randomized traffic on both packers
      for (int i = 0; i < 2; i++) begin
         for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
            send(i, 8'($urandom), $urandom_range(0, 7) == 0);
         end
         tick(8);
      end

      tick(4);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/a_frame_packer.md
# a_frame_packer

Transmit-side driver for the 8-lane `a_if` byte-frame protocol. It accepts a serial byte stream on a valid/ready handshake, packs the bytes into lanes `a`..`a7`, and drives the interface as the output side: one-cycle `valid` pulse, lane data held. It sits between a byte source and the classified DUT. It enforces a configurable minimum idle gap between frames and pads short frames.

## Interface
- `GAP_CYCLES`, default 0: minimum number of low cycles between consecutive `valid` pulses (range 0..15).
- `PAD_BYTE`, default 8'h00: value written to lanes left unfilled by a short frame.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream byte present.
- `in_data`  in  8  upstream byte.
- `in_last`  in  1  accepted byte ends the current frame early.
- `in_ready`  out  1  packer can accept a byte this cycle.
- `valid`  out  1  frame strobe on `a_if`; high for exactly one cycle per frame.
- `a`, `a1`, `a2`, `a3`, `a4`, `a5`, `a6`, `a7`  out  8 each  frame lanes.
- `frame_count`  out  16  number of frames emitted; wraps from 16'hFFFF to 0.

## Operation
- Accept: a byte is accepted when `in_valid && in_ready`. `in_data`/`in_last` are ignored otherwise.
- Lane order: the k-th accepted byte of a frame goes to lane k (first byte to `a`).
- Frame length N = 8. With the checksum feature enabled, N = 7.
- Completion: a frame completes on the edge that accepts byte N, or any byte with `in_last=1`. Lanes not filled get `PAD_BYTE`.
- Gap counter `gap` (4 bits):
  - loaded with `GAP_CYCLES` on each emission edge;
  - decrements by 1 on every other edge while nonzero.
- States:
  - FILL: `in_ready=1`. On the completion edge:
    - if `gap==0`, emit: load lanes, set `valid`, increment `frame_count`, stay in FILL;
    - else go to PEND holding the assembled frame.
  - PEND: `in_ready=0`. On the first edge with `gap==0`, emit and return to FILL.
- Emission:
  - lanes update and `valid=1` for the following cycle only;
  - lanes hold their values until the next emission.
- Fill counter resets to 0 on every completion edge.
- Reset asserted at any time:
  - the partial frame and any pending frame are discarded;
  - state returns to FILL with an empty fill counter.
- Reset values: `valid=0`, `a`..`a7`=8'h00, `frame_count=0`, `gap=0`, state FILL, so `in_ready=1` once reset deasserts.

## Timing
- `in_ready` is combinational from state only (`state==FILL`); it has no combinational path from `in_valid`.
- Latency:
  - completion byte accepted at edge E with `gap==0` gives `valid` high in the cycle after E, with lanes valid that same cycle;
  - if the frame waits in PEND, `valid` rises the cycle after the first edge with `gap==0`.
- Throughput at `GAP_CYCLES=0` is one byte per cycle with no PEND cycles.
- Pulse spacing: between two `valid` pulses there are at least `GAP_CYCLES` low cycles.
- `in_valid` low mid-frame: no state change other than `gap` decrementing.

## Configuration
- Macro `A_PACK_CHECKSUM_EN`.
- Defined:
  - N = 7;
  - `a7` = XOR of the final `a`..`a6` (padding included), computed at emission;
  - `in_last` on byte 7 is redundant but legal.
- Undefined:
  - N = 8;
  - `a7` carries the 8th byte or `PAD_BYTE`.

## Test plan
- `GAP_CYCLES=0`; bytes 01..08 on consecutive cycles:
  - `valid` one cycle after 08 is accepted, with `a`=01 through `a7`=08;
  - `in_ready` stays 1 throughout; `frame_count`=1.
- `PAD_BYTE`=8'hEE; AA, BB, CC with `in_last` on CC:
  - `a`=AA, `a1`=BB, `a2`=CC, `a3`..`a7`=EE;
  - the next byte starts a new frame in lane `a`.
- `GAP_CYCLES=3`; 16 bytes streamed continuously:
  - second `valid` comes at least 3 low cycles after the first;
  - `in_ready`=0 only while PEND;
  - all 16 bytes appear in order, none lost; `frame_count`=2.
- Reset asserted after 4 bytes, then 11..18 sent:
  - during reset: `valid`=0, lanes 00;
  - after reset, one frame `a`=11..`a7`=18.
- `in_valid` toggling 1/0 across bytes 01..08: the frame equals the contiguous case and `valid` pulses exactly once.
- `A_PACK_CHECKSUM_EN` defined; bytes 01, 02, 04, 08, 10, 20, 40: `valid` after the 7th byte, `a7`=7F.
